// File: rtl/spi_flash_drive_if.sv
// rtl/spi_flash_drive_if.sv - sequencer/flash-pin bundle for spi_flash_drive
interface spi_flash_drive_if;
  logic       spi_start;
  logic [7:0] spi_cmd;
  logic [7:0] spi_data;
  logic       idel_flag_r;
  logic       w_data_req;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] sta_reg;
  logic       busy;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  // Driver side: takes commands and write bytes, drives the flash pins.
  modport master (
    input  spi_start, spi_cmd, spi_data, spi_miso,
    output idel_flag_r, w_data_req, rd_data, rd_valid, sta_reg, busy,
           spi_cs_n, spi_sclk, spi_mosi
  );

  // Sequencer/flash side.
  modport slave (
    output spi_start, spi_cmd, spi_data, spi_miso,
    input  idel_flag_r, w_data_req, rd_data, rd_valid, sta_reg, busy,
           spi_cs_n, spi_sclk, spi_mosi
  );
endinterface

// File: rtl/spi_flash_drive.sv
// rtl/spi_flash_drive.sv - SPI mode-0 master expanding one flash opcode into a full frame
module spi_flash_drive #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  parameter int unsigned RW_LEN     = 10,
  parameter int unsigned CS_IDLE    = 4
) (
  input logic               sys_clk,
  input logic               sys_rst,
  spi_flash_drive_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, CS_LOW, CMD, ADDR, WDATA, RDATA, POLL, CS_HIGH, GAP
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_IDLE - 1);
  localparam logic [8:0]  RW_LAST   = 9'(RW_LEN - 1);

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic [6:0]  shift_q, shift_d;   // remaining tx bits of the current byte, MSB next
  logic [6:0]  rx_q, rx_d;         // rx bits gathered so far in the current byte
  logic [2:0]  bit_q, bit_d;
  logic [8:0]  byte_q, byte_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        busy_q, busy_d;
  logic        idel_q, idel_d;
  logic        wreq_q, wreq_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [7:0]  sta_q, sta_d;

  logic        half_end;
  logic        gap_end;
  logic [7:0]  rx_byte;
  logic        finish;
  logic [7:0]  load_val;

  assign half_end = (div_q == HALF_LAST);
  assign gap_end  = (div_q == GAP_LAST);
  assign rx_byte  = {rx_q, bus.spi_miso};

  assign bus.spi_cs_n    = cs_n_q;
  assign bus.spi_sclk    = sclk_q;
  assign bus.spi_mosi    = mosi_q;
  assign bus.busy        = busy_q;
  assign bus.idel_flag_r = idel_q;
  assign bus.w_data_req  = wreq_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.sta_reg     = sta_q;

  // Frame sequencing: half-period timing, bit shifting and byte-boundary decisions.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q + 16'd1;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    shift_d    = shift_q;
    rx_d       = rx_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    cmd_d      = cmd_q;
    busy_d     = busy_q;
    idel_d     = 1'b0;
    wreq_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    sta_d      = sta_q;
    finish     = 1'b0;
    load_val   = 8'h00;

    case (state_q)
      IDLE: begin
        div_d = '0;
        if (bus.spi_start) begin
          cmd_d   = bus.spi_cmd;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
          mosi_d  = bus.spi_cmd[7];
          shift_d = bus.spi_cmd[6:0];
          bit_d   = 3'd0;
          byte_d  = 9'd0;
          state_d = CS_LOW;
        end
      end

      // Leading low half of bit 0; MOSI already holds the opcode MSB.
      CS_LOW: begin
        if (half_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = rx_byte[6:0];
          state_d = CMD;
        end
      end

      CMD, ADDR, WDATA, RDATA, POLL: begin
        if (half_end) begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising edge: sample MISO; a completed byte lands on rd_data or sta_reg.
            sclk_d = 1'b1;
            rx_d   = rx_byte[6:0];
            if (bit_q == 3'd7) begin
              if (state_q == RDATA) begin
                rd_data_d  = rx_byte;
                rd_valid_d = 1'b1;
              end
              if (state_q == POLL) sta_d = rx_byte;
            end
          end else begin
            // Falling edge: present the next bit, or pick the next byte at a boundary.
            sclk_d = 1'b0;
            if (bit_q != 3'd7) begin
              bit_d   = bit_q + 3'd1;
              mosi_d  = shift_q[6];
              shift_d = {shift_q[5:0], 1'b0};
            end else begin
              bit_d = 3'd0;
              case (state_q)
                CMD: begin
                  if (cmd_q == 8'h20 || cmd_q == 8'h02 || cmd_q == 8'h03) begin
                    state_d  = ADDR;
                    byte_d   = 9'd0;
                    load_val = FLASH_ADDR[23:16];
                  end else if (cmd_q == 8'h05) begin
                    state_d = POLL;
                  end else begin
                    finish = 1'b1;
                  end
                end
                ADDR: begin
                  if (byte_q == 9'd2) begin
                    byte_d = 9'd0;
                    if (cmd_q == 8'h02) begin
                      state_d  = WDATA;
                      load_val = bus.spi_data;
                      wreq_d   = 1'b1;
                    end else if (cmd_q == 8'h03) begin
                      state_d = RDATA;
                    end else begin
                      finish = 1'b1;
                    end
                  end else begin
                    byte_d   = byte_q + 9'd1;
                    load_val = (byte_q == 9'd0) ? FLASH_ADDR[15:8] : FLASH_ADDR[7:0];
                  end
                end
                WDATA: begin
                  if (byte_q == RW_LAST) begin
                    finish = 1'b1;
                  end else begin
                    byte_d   = byte_q + 9'd1;
                    load_val = bus.spi_data;
                    wreq_d   = 1'b1;
                  end
                end
                RDATA: begin
                  if (byte_q == RW_LAST) finish = 1'b1;
                  else byte_d = byte_q + 9'd1;
                end
                POLL: begin
                  // Keep polling while the write-in-progress bit is still set.
                  if (!sta_q[0]) finish = 1'b1;
                end
                default: finish = 1'b1;
              endcase
              if (finish) begin
                state_d = CS_HIGH;
                mosi_d  = 1'b0;
              end else begin
                shift_d = load_val[6:0];
                mosi_d  = load_val[7];
              end
            end
          end
        end
      end

      // Trailing low half doubles as CS hold time.
      CS_HIGH: begin
        if (half_end) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          state_d = GAP;
        end
      end

      GAP: begin
        if (idel_q) begin
          div_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (gap_end) begin
          idel_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      shift_q    <= '0;
      rx_q       <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      cmd_q      <= '0;
      busy_q     <= 1'b0;
      idel_q     <= 1'b0;
      wreq_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      sta_q      <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      shift_q    <= shift_d;
      rx_q       <= rx_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      cmd_q      <= cmd_d;
      busy_q     <= busy_d;
      idel_q     <= idel_d;
      wreq_q     <= wreq_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      sta_q      <= sta_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_drive.sv
// tb/tb_spi_flash_drive.sv - directed self-checking bench for spi_flash_drive
module tb_spi_flash_drive;
  localparam int CLK_DIV = 2;
  localparam int RW_LEN  = 10;
  localparam int CS_IDLE = 4;
  localparam logic [23:0] ADDR = 24'hA1B2C3;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  spi_flash_drive_if bus();

  spi_flash_drive #(
    .CLK_DIV(CLK_DIV), .FLASH_ADDR(ADDR), .RW_LEN(RW_LEN), .CS_IDLE(CS_IDLE)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // cycle counter, advanced on the active edge
  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  // monitor + flash model state (written only by the monitor)
  logic       prev_sclk = 1'b0;
  logic       prev_cs   = 1'b1;
  int         rise_cyc[$];
  logic       mosi_bits[$];
  logic [7:0] rd_vals[$];
  int         wreq_cyc[$];
  int         frame_rises = 0;
  int         cs_fall_cyc = 0;
  int         cs_rise_cyc = 0;
  int         idel_cyc = 0;
  int         idel_total = 0;
  int         wreq_total = 0;
  int         sclk_tog = 0;

  // flash response configuration (written only by the test sequence)
  logic [7:0] resp[0:15];
  int         resp_off = 1000;

  // per-command snapshots
  int t0, rb, wb, ib, vb;

  always @(negedge sys_clk) begin
    if (bus.spi_sclk !== prev_sclk) sclk_tog++;
    if (bus.spi_cs_n === 1'b0 && prev_cs === 1'b1) begin
      cs_fall_cyc = cyc;
      frame_rises = 0;
    end
    if (bus.spi_cs_n === 1'b1 && prev_cs === 1'b0) cs_rise_cyc = cyc;
    if (bus.spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
      rise_cyc.push_back(cyc);
      mosi_bits.push_back(bus.spi_mosi);
      frame_rises++;
    end
    if (bus.idel_flag_r === 1'b1) begin
      idel_total++;
      idel_cyc = cyc;
    end
    if (bus.w_data_req === 1'b1) begin
      wreq_cyc.push_back(cyc);
      wreq_total++;
    end
    if (bus.rd_valid === 1'b1) rd_vals.push_back(bus.rd_data);
    bus.spi_data = 8'(wreq_total);
    if (frame_rises >= resp_off) begin
      int n;
      n = frame_rises - resp_off;
      bus.spi_miso = resp[(n / 8) % 16][7 - (n % 8)];
    end else begin
      bus.spi_miso = 1'b0;
    end
    prev_sclk = bus.spi_sclk;
    prev_cs   = bus.spi_cs_n;
  end

  function automatic logic [7:0] mbyte(int base, int k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = mosi_bits[base + 8*k + i];
    return r;
  endfunction

  task automatic send_cmd(input logic [7:0] c);
    @(negedge sys_clk);
    bus.spi_start = 1'b1;
    bus.spi_cmd   = c;
    t0 = cyc;
    rb = rise_cyc.size();
    wb = wreq_total;
    ib = idel_total;
    vb = rd_vals.size();
    @(negedge sys_clk);
    bus.spi_start = 1'b0;
    bus.spi_cmd   = 8'h00;
  endtask

  task automatic wait_idel(input string name, input int budget);
    int i;
    i = 0;
    while (idel_total == ib && i < budget) begin
      @(negedge sys_clk);
      #1;
      i++;
    end
    n_cmp++;
    if (idel_total == ib) begin
      n_bad++;
      $display("FAIL %s_timeout: no idel_flag_r within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    bus.spi_start = 1'b0;
    bus.spi_cmd   = 8'h00;
    sys_rst = 1'b1;
    repeat (4) @(negedge sys_clk);
    n_cmp++;
    if ({bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi, bus.busy} !== 4'b1000) begin
      n_bad++;
      $display("FAIL rst_pins: got cs,sclk,mosi,busy=%b need 1000",
               {bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi, bus.busy});
    end
    n_cmp++;
    if ({bus.idel_flag_r, bus.w_data_req, bus.rd_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_pulses: got idel,wreq,rdv=%b need 000",
               {bus.idel_flag_r, bus.w_data_req, bus.rd_valid});
    end
    n_cmp++;
    if ({bus.rd_data, bus.sta_reg} !== 16'h0000) begin
      n_bad++;
      $display("FAIL rst_data: got rd_data,sta_reg=%h need 0000", {bus.rd_data, bus.sta_reg});
    end
    sys_rst = 1'b0;
    ib = idel_total;
    wb = sclk_tog;
    repeat (100) @(negedge sys_clk);
    n_cmp++;
    if (sclk_tog !== wb) begin
      n_bad++;
      $display("FAIL rst_idle_sclk: got %0d toggles need 0", sclk_tog - wb);
    end
    n_cmp++;
    if (idel_total !== ib || bus.spi_cs_n !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_idle_flag: got idel=%0d cs_n=%b need 0 1", idel_total - ib, bus.spi_cs_n);
    end
  endtask

  task automatic test_wel();
    send_cmd(8'h06);
    wait_idel("wel", 100);
    n_cmp++;
    if (cs_fall_cyc - t0 !== 1) begin
      n_bad++; $display("FAIL wel_cs_fall: got %0d need 1", cs_fall_cyc - t0);
    end
    n_cmp++;
    if (rise_cyc.size() - rb !== 8) begin
      n_bad++; $display("FAIL wel_rises: got %0d need 8", rise_cyc.size() - rb);
    end else begin
      n_cmp++;
      if (rise_cyc[rb] - t0 !== 3 || rise_cyc[rb+7] - t0 !== 31) begin
        n_bad++;
        $display("FAIL wel_rise_cyc: got %0d..%0d need 3..31", rise_cyc[rb] - t0, rise_cyc[rb+7] - t0);
      end
      n_cmp++;
      if (mbyte(rb, 0) !== 8'h06) begin
        n_bad++; $display("FAIL wel_mosi: got %h need 06", mbyte(rb, 0));
      end
    end
    n_cmp++;
    if (cs_rise_cyc - t0 !== 35 || idel_cyc - t0 !== 39) begin
      n_bad++;
      $display("FAIL wel_end: got cs_rise %0d idel %0d need 35 39", cs_rise_cyc - t0, idel_cyc - t0);
    end
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL wel_busy_at_idel: got %b need 1", bus.busy);
    end
    @(negedge sys_clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL wel_busy_after: got %b need 0", bus.busy);
    end
  endtask

  task automatic test_program();
    logic [7:0] exp;
    send_cmd(8'h02);
    wait_idel("prog", 700);
    n_cmp++;
    if (wreq_total - wb !== 10) begin
      n_bad++; $display("FAIL prog_wreq_count: got %0d need 10", wreq_total - wb);
    end else begin
      n_cmp++;
      if (wreq_cyc[wb] - t0 !== 129) begin
        n_bad++; $display("FAIL prog_wreq_first: got %0d need 129", wreq_cyc[wb] - t0);
      end
    end
    n_cmp++;
    if (rise_cyc.size() - rb !== 112) begin
      n_bad++; $display("FAIL prog_rises: got %0d need 112", rise_cyc.size() - rb);
    end else begin
      for (int k = 0; k < 14; k++) begin
        case (k)
          0: exp = 8'h02;
          1: exp = ADDR[23:16];
          2: exp = ADDR[15:8];
          3: exp = ADDR[7:0];
          default: exp = 8'(k - 4);
        endcase
        n_cmp++;
        if (mbyte(rb, k) !== exp) begin
          n_bad++; $display("FAIL prog_byte%0d: got %h need %h", k, mbyte(rb, k), exp);
        end
      end
    end
    n_cmp++;
    if (cs_rise_cyc - t0 !== 451 || idel_cyc - t0 !== 455) begin
      n_bad++;
      $display("FAIL prog_end: got cs_rise %0d idel %0d need 451 455", cs_rise_cyc - t0, idel_cyc - t0);
    end
  endtask

  task automatic test_read();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) resp[i] = (i % 2 == 0) ? 8'hA5 : 8'h5A;
    resp_off = 32;
    send_cmd(8'h03);
    wait_idel("read", 700);
    resp_off = 1000;
    n_cmp++;
    if (rd_vals.size() - vb !== 10) begin
      n_bad++; $display("FAIL read_rdv_count: got %0d need 10", rd_vals.size() - vb);
    end else begin
      for (int i = 0; i < 10; i++) begin
        exp = (i % 2 == 0) ? 8'hA5 : 8'h5A;
        n_cmp++;
        if (rd_vals[vb+i] !== exp) begin
          n_bad++; $display("FAIL read_data%0d: got %h need %h", i, rd_vals[vb+i], exp);
        end
      end
    end
    n_cmp++;
    if (rise_cyc.size() - rb !== 112) begin
      n_bad++; $display("FAIL read_rises: got %0d need 112", rise_cyc.size() - rb);
    end else begin
      n_cmp++;
      if ({mbyte(rb, 0), mbyte(rb, 1), mbyte(rb, 2), mbyte(rb, 3)} !== {8'h03, ADDR}) begin
        n_bad++;
        $display("FAIL read_hdr: got %h%h%h%h need 03%h", mbyte(rb, 0), mbyte(rb, 1),
                 mbyte(rb, 2), mbyte(rb, 3), ADDR);
      end
    end
    n_cmp++;
    if (bus.rd_data !== 8'h5A || bus.sta_reg !== 8'h00) begin
      n_bad++; $display("FAIL read_final: got rd %h sta %h need 5a 00", bus.rd_data, bus.sta_reg);
    end
  endtask

  task automatic test_poll();
    resp[0] = 8'h03;
    resp[1] = 8'h03;
    resp[2] = 8'h00;
    resp_off = 8;
    send_cmd(8'h05);
    wait_idel("poll", 300);
    resp_off = 1000;
    n_cmp++;
    if (rise_cyc.size() - rb !== 32) begin
      n_bad++; $display("FAIL poll_rises: got %0d need 32", rise_cyc.size() - rb);
    end else begin
      n_cmp++;
      if (mbyte(rb, 0) !== 8'h05 || mbyte(rb, 1) !== 8'h00) begin
        n_bad++; $display("FAIL poll_mosi: got %h %h need 05 00", mbyte(rb, 0), mbyte(rb, 1));
      end
    end
    n_cmp++;
    if (bus.sta_reg !== 8'h00 || rd_vals.size() - vb !== 0) begin
      n_bad++;
      $display("FAIL poll_sta: got sta %h rdv %0d need 00 0", bus.sta_reg, rd_vals.size() - vb);
    end
    n_cmp++;
    if (cs_rise_cyc - t0 !== 131 || idel_cyc - t0 !== 135) begin
      n_bad++;
      $display("FAIL poll_end: got cs_rise %0d idel %0d need 131 135", cs_rise_cyc - t0, idel_cyc - t0);
    end
  endtask

  task automatic test_ignore_and_abort();
    send_cmd(8'h06);
    repeat (8) @(negedge sys_clk);
    bus.spi_start = 1'b1;
    bus.spi_cmd   = 8'h02;
    @(negedge sys_clk);
    bus.spi_start = 1'b0;
    bus.spi_cmd   = 8'h00;
    wait_idel("ign", 100);
    repeat (50) @(negedge sys_clk);
    n_cmp++;
    if (rise_cyc.size() - rb !== 8 || idel_total - ib !== 1 || wreq_total !== wb) begin
      n_bad++;
      $display("FAIL ign_frame: got rises %0d idel %0d wreq %0d need 8 1 0",
               rise_cyc.size() - rb, idel_total - ib, wreq_total - wb);
    end else begin
      n_cmp++;
      if (mbyte(rb, 0) !== 8'h06) begin
        n_bad++; $display("FAIL ign_mosi: got %h need 06", mbyte(rb, 0));
      end
    end
    send_cmd(8'h02);
    repeat (150) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi, bus.busy} !== 4'b1000) begin
      n_bad++;
      $display("FAIL abort_pins: got cs,sclk,mosi,busy=%b need 1000",
               {bus.spi_cs_n, bus.spi_sclk, bus.spi_mosi, bus.busy});
    end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    ib = idel_total;
    repeat (100) @(negedge sys_clk);
    n_cmp++;
    if (idel_total !== ib || bus.spi_cs_n !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_resume: got idel %0d cs_n %b need 0 1", idel_total - ib, bus.spi_cs_n);
    end
    send_cmd(8'h06);
    wait_idel("post_abort", 100);
    n_cmp++;
    if (rise_cyc.size() - rb !== 8 || idel_cyc - t0 !== 39) begin
      n_bad++;
      $display("FAIL post_abort: got rises %0d idel %0d need 8 39", rise_cyc.size() - rb, idel_cyc - t0);
    end else begin
      n_cmp++;
      if (mbyte(rb, 0) !== 8'h06) begin
        n_bad++; $display("FAIL post_abort_mosi: got %h need 06", mbyte(rb, 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    send_cmd(8'h06);
    wait_idel("b2b_first", 100);
    send_cmd(8'h20);
    wait_idel("b2b_second", 300);
    n_cmp++;
    if (cs_fall_cyc - t0 !== 1) begin
      n_bad++; $display("FAIL b2b_accept: got cs_fall %0d need 1", cs_fall_cyc - t0);
    end
    n_cmp++;
    if (rise_cyc.size() - rb !== 32) begin
      n_bad++; $display("FAIL b2b_rises: got %0d need 32", rise_cyc.size() - rb);
    end else begin
      n_cmp++;
      if ({mbyte(rb, 0), mbyte(rb, 1), mbyte(rb, 2), mbyte(rb, 3)} !== {8'h20, ADDR}) begin
        n_bad++;
        $display("FAIL b2b_hdr: got %h%h%h%h need 20%h", mbyte(rb, 0), mbyte(rb, 1),
                 mbyte(rb, 2), mbyte(rb, 3), ADDR);
      end
    end
    n_cmp++;
    if (idel_cyc - t0 !== 135) begin
      n_bad++; $display("FAIL b2b_idel: got %0d need 135", idel_cyc - t0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;
    test_reset();
    test_wel();
    test_program();
    test_read();
    test_poll();
    test_ignore_and_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_flash_drive.md
# spi_flash_drive

SPI-mode-0 master that executes single flash commands issued by the flash command sequencer and drives the serial flash pins. It accepts one opcode per `spi_start` pulse and expands it into the full serial frame: opcode, 24-bit address, write payload, read payload or status polling. It returns `idel_flag_r` on completion, which advances the sequencer, and pulls write bytes from it with `w_data_req`.

## Interface

Parameters:
- `CLK_DIV`, 2: sys_clk cycles per SCLK half-period; legal 1..255.
- `FLASH_ADDR`, 24'h000000: address sent with 0x20, 0x03, 0x02.
- `RW_LEN`, 10: data bytes per 0x03 read / 0x02 program; legal 1..256.
- `CS_IDLE`, 4: sys_clk cycles `spi_cs_n` stays high before `idel_flag_r`; legal ≥1.

Ports. One clock; reset is asynchronous and active-high.
- `sys_clk`, in, 1: clock.
- `sys_rst`, in, 1: asynchronous active-high reset.
- `spi_start`, in, 1: command strobe; sampled only in IDLE.
- `spi_cmd`, in, 8: opcode, valid while `spi_start`=1.
- `spi_data`, in, 8: next program byte, captured when `w_data_req`=1.
- `idel_flag_r`, out, 1: one-cycle pulse, command finished.
- `w_data_req`, out, 1: one-cycle pulse, `spi_data` captured this cycle.
- `rd_data`, out, 8: last byte read by 0x03.
- `rd_valid`, out, 1: one-cycle pulse, `rd_data` updated.
- `sta_reg`, out, 8: last status byte read by 0x05.
- `busy`, out, 1: high from accept until `idel_flag_r`, inclusive.
- `spi_cs_n`, out, 1: chip select.
- `spi_sclk`, out, 1: serial clock.
- `spi_mosi`, out, 1: serial data out.
- `spi_miso`, in, 1: serial data in.

## Operation

- States: IDLE → CS_LOW → CMD → (ADDR) → (WDATA | RDATA | POLL) → CS_HIGH → GAP → IDLE.
- IDLE: `spi_start`=1 latches `spi_cmd` and sets `busy`. `spi_start` in any other state is ignored.
- Frames, all MSB first:
  - 0x06, 0xC7, and any unlisted opcode: 8 bits.
  - 0x20: 8 + 24 address bits.
  - 0x02: 8 + 24 + 8·RW_LEN bits.
  - 0x03: 8 + 24 + 8·RW_LEN bits.
  - 0x05: 8 + 8·k bits. Status bytes are read back-to-back with CS held low. `sta_reg` updates after each byte. The frame ends after the first byte with bit0 (WIP) = 0, so k ≥ 1.
- 0x02: for each payload byte, the driver loads `spi_data` into the shift register and pulses `w_data_req` in the same cycle. This happens CLK_DIV cycles before that byte's first SCLK rise. It yields exactly RW_LEN pulses. The sequencer advances `spi_data` after each pulse.
- 0x03: after each 8th payload sample, `rd_data` is updated and `rd_valid` pulses, RW_LEN times. No `rd_valid` for 0x05.
- Address and counter arithmetic is unsigned. The byte counter is 9 bits so RW_LEN=256 does not wrap.
- Reset at any point: `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `idel_flag_r`=0, `w_data_req`=0, `rd_valid`=0, `rd_data`=0, `sta_reg`=0, `busy`=0, state IDLE. An aborted frame is not resumed. No `idel_flag_r` is generated after reset.

## Timing

- Cycle 0 is the accept cycle. `spi_cs_n` falls at cycle 1.
- Each bit is 2·CLK_DIV cycles: SCLK low half, then high half. The first rise is at cycle 1+CLK_DIV. SCLK idles low.
- `spi_mosi` changes only while SCLK is low: at CS fall for bit 0, otherwise on the cycle SCLK falls.
- `spi_miso` is sampled on the sys_clk edge that drives SCLK 0→1.
- `spi_cs_n` stays low for (2·nbits+1)·CLK_DIV cycles. The final low half acts as CS hold.
- `idel_flag_r` pulses CS_IDLE cycles after `spi_cs_n` rises. `busy` drops the cycle after the pulse. A `spi_start` arriving in that following cycle is accepted.
- WEL example, CLK_DIV=2, CS_IDLE=4: CS low at cycle 1, rises at 3, 7, …, 31, last fall at 33, CS high at 35, `idel_flag_r` at 39.

## Test plan

- Reset held, then released: all outputs at reset values. No SCLK toggles and no `idel_flag_r` for 100 cycles.
- `spi_start` with 0x06, CLK_DIV=2: MOSI 00000110 captured on rises at cycles 3..31. CS high at 35, `idel_flag_r` at 39.
- 0x02, RW_LEN=10, `spi_data` incremented on each `w_data_req`, starting at 0: exactly 10 pulses. MOSI payload is 0x00..0x09 after 0x02,00,00,00.
- 0x03, MISO model returns 0xA5, 0x5A alternating: 10 `rd_valid` pulses, `rd_data` alternating A5/5A, 32 command/address bits correct.
- 0x05, model returns 0x03, 0x03, 0x00: CS stays low for 8+24 bits. `sta_reg` ends at 0x00, one `idel_flag_r`.
- `spi_start` pulsed mid-frame is ignored. Reset asserted mid-0x02 returns CS high immediately. A following 0x06 runs normally.
